// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
package wbm_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned TMO_W              = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/wbm_timeout_cnt.sv
// Counts BUS cycles without ack; expire_c flags the last cycle before abort.
module wbm_timeout_cnt
  import wbm_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [TMO_W-1:0] cnt_q;

  // Clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign expire_c = (cnt_q == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/wbm_initiator.sv
// Single-outstanding Wishbone classic master driven by a command/response handshake.
module wbm_initiator
  import wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic [CNT_W-1:0] txn_cnt_o
);

  wbm_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_clr, tmo_en, tmo_expire_c;

  wbm_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .expire_c (tmo_expire_c)
  );

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output decode; registered outputs follow state_d.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          tmo_clr = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack wins over a coinciding timeout.
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = ST_RESP;
        end else if (tmo_expire_c) begin
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = ST_RESP;
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d     = (state_d == ST_IDLE);
    cyc_d       = (state_d == ST_BUS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  assign cmd_ready_o = ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign txn_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wbm_initiator.sv
// Directed bench for wbm_initiator with TIMEOUT_CYCLES=4 and CNT_W=2.
module tb_wbm_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] ack_dat;
  logic [1:0]  txn_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wbm_initiator #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_sel_i   (cmd_sel),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat),
    .wbm_ack_i   (ack),
    .wbm_dat_i   (ack_dat),
    .txn_cnt_o   (txn_cnt)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle; afterwards the DUT is in its first BUS cycle.
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Act as slave: ack after wait_n wait cycles (if ack_en); n returns cycles with cyc high.
  task automatic run_bus(input int wait_n, input bit ack_en, input logic [31:0] d, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cyc) break;
      n++;
      if (ack_en && n == wait_n + 1) begin
        ack = 1'b1; ack_dat = d;
      end
      tick();
      ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 00000", {cyc, stb, we, rsp_valid, rsp_err});
    end
    checks++;
    if ({sel, adr, dat, rsp_dat, txn_cnt} !== '0) begin
      errors++; $display("FAIL reset_data: sel=%h adr=%h dat=%h rsp=%h cnt=%0d want all 0", sel, adr, dat, rsp_dat, txn_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int n;
    issue(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF);
    checks++;
    if ({cmd_ready, we, sel, adr, dat} !== {1'b0, 1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_bus: rdy=%b we=%b sel=%h adr=%h dat=%h want 0 1 f 30000004 deadbeef", cmd_ready, we, sel, adr, dat);
    end
    run_bus(2, 1'b1, 32'hFFFF_FFFF, n);
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL wr_cyc_len: got %0d want 3", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, txn_cnt, stb} !== {1'b1, 1'b0, 32'h0, 2'd1, 1'b0}) begin
      errors++; $display("FAIL wr_rsp: v=%b err=%b dat=%h cnt=%0d stb=%b want 1 0 0 1 0", rsp_valid, rsp_err, rsp_dat, txn_cnt, stb);
    end
    checks++;
    if ({adr, dat} !== {32'h3000_0004, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_hold: adr=%h dat=%h want 30000004 deadbeef", adr, dat);
    end
    tick();
  endtask

  task automatic test_read();
    // Ack held high from IDLE onward: ignored until BUS, then a zero-wait read.
    ack = 1'b1; ack_dat = 32'h1234_5678;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0008; cmd_dat = 32'h0;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({cyc, rsp_valid, we, adr} !== {1'b1, 1'b0, 1'b0, 32'h3000_0008}) begin
      errors++; $display("FAIL rd_bus: cyc=%b v=%b we=%b adr=%h want 1 0 0 30000008", cyc, rsp_valid, we, adr);
    end
    tick();
    ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, txn_cnt, cyc} !== {1'b1, 1'b0, 32'h1234_5678, 2'd2, 1'b0}) begin
      errors++; $display("FAIL rd_rsp: v=%b err=%b dat=%h cnt=%0d cyc=%b want 1 0 12345678 2 0", rsp_valid, rsp_err, rsp_dat, txn_cnt, cyc);
    end
    tick();
    // Stray ack in IDLE must not start or alter anything.
    ack = 1'b1; ack_dat = 32'hAAAA_5555;
    repeat (2) tick();
    ack = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, cyc, rsp_dat, txn_cnt} !== {1'b1, 1'b0, 1'b0, 32'h1234_5678, 2'd2}) begin
      errors++; $display("FAIL idle_ack: rdy=%b v=%b cyc=%b dat=%h cnt=%0d want 1 0 0 12345678 2", cmd_ready, rsp_valid, cyc, rsp_dat, txn_cnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b0, 4'h3, 32'h3000_0010, 32'h0);
    run_bus(0, 1'b0, 32'h0, n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL tmo_cyc_len: got %0d want 4", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, txn_cnt} !== {1'b1, 1'b1, 32'h0, 2'd3}) begin
      errors++; $display("FAIL tmo_rsp: v=%b err=%b dat=%h cnt=%0d want 1 1 0 3", rsp_valid, rsp_err, rsp_dat, txn_cnt);
    end
    tick();
  endtask

  task automatic test_ack_on_timeout();
    int n;
    issue(1'b0, 4'hF, 32'h3000_0014, 32'h0);
    run_bus(3, 1'b1, 32'hCAFE_F00D, n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL ackto_cyc_len: got %0d want 4", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, txn_cnt} !== {1'b1, 1'b0, 32'hCAFE_F00D, 2'd0}) begin
      errors++; $display("FAIL ackto_rsp: v=%b err=%b dat=%h cnt=%0d want 1 0 cafef00d 0", rsp_valid, rsp_err, rsp_dat, txn_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    issue(1'b0, 4'h1, 32'h3000_0020, 32'h0);
    run_bus(0, 1'b1, 32'h0BAD_F00D, n);
    // Offer a new command while the response is stalled; it must not be taken.
    cmd_valid = 1'b1; cmd_adr = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat, cmd_ready, cyc} !== {1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d]: v=%b err=%b dat=%h rdy=%b cyc=%b want 1 0 0badf00d 0 0", i, rsp_valid, rsp_err, rsp_dat, cmd_ready, cyc);
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, cmd_ready, txn_cnt, adr} !== {1'b0, 1'b1, 2'd1, 32'h3000_0020}) begin
      errors++; $display("FAIL bp_release_wrap: v=%b rdy=%b cnt=%0d adr=%h want 0 1 1 30000020", rsp_valid, cmd_ready, txn_cnt, adr);
    end
  endtask

  task automatic test_back_to_back();
    // Zero-wait ack with rsp_ready high: command accepted every 3 cycles.
    ack = 1'b1; ack_dat = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h5000_0000;
    tick(); // accepted -> BUS
    tick(); // RESP
    tick(); // IDLE again
    checks++;
    if ({cmd_ready, cyc, txn_cnt} !== {1'b1, 1'b0, 2'd2}) begin
      errors++; $display("FAIL b2b_idle: rdy=%b cyc=%b cnt=%0d want 1 0 2", cmd_ready, cyc, txn_cnt);
    end
    cmd_adr = 32'h5000_0004;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({cyc, adr} !== {1'b1, 32'h5000_0004}) begin
      errors++; $display("FAIL b2b_second: cyc=%b adr=%h want 1 50000004", cyc, adr);
    end
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b0, 4'hF, 32'h3000_0030, 32'h0);
    tick();
    checks++;
    if (cyc !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: cyc=%b want 1", cyc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, stb, rsp_valid, txn_cnt} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL rst_mid: cyc=%b stb=%b v=%b cnt=%0d want 0 0 0 0", cyc, stb, rsp_valid, txn_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, rsp_valid, cyc} !== 3'b100) begin
      errors++; $display("FAIL rst_mid_after: rdy=%b v=%b cyc=%b want 1 0 0", cmd_ready, rsp_valid, cyc);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b1; ack = 1'b0; ack_dat = '0;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_on_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbm_initiator.md
WBM_INITIATOR -- requirements
Module: wbm_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of BUS cycles without ack before abort (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the completed-transaction counter.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all flops on the rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have cmd_valid_i/cmd_ready_o, in/out, 1/1, command handshake.
REQ-006 SHALL have cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i, inputs, 1/4/32/32, command fields.
REQ-007 SHALL have rsp_valid_o/rsp_ready_i, out/in, 1/1, response handshake.
REQ-008 SHALL have rsp_dat_o (32), rsp_err_o (1), outputs, read data and timeout flag.
REQ-009 SHALL have wbm_cyc_o, wbm_stb_o, wbm_we_o (1 each), wbm_sel_o (4), wbm_adr_o (32), wbm_dat_o (32), outputs, Wishbone classic master.
REQ-010 SHALL have wbm_ack_i (1), wbm_dat_i (32), inputs, slave response.
REQ-011 SHALL have txn_cnt_o, output, CNT_W, count of completed transactions, ack or timeout.

Function
REQ-012 SHALL implement the FSM states IDLE, BUS and RESP.
REQ-013 In IDLE, cmd_ready_o SHALL be 1; in BUS and RESP it SHALL be 0.
REQ-014 On cmd_valid_i & cmd_ready_o at an edge, SHALL latch all cmd fields and go to BUS; in the next cycle cyc/stb SHALL be 1.
REQ-015 In BUS, wbm_cyc_o and wbm_stb_o SHALL be 1, and we/sel/adr/dat SHALL hold the latched values, stable until termination.
REQ-016 Outside BUS, cyc/stb SHALL be 0; we/sel/adr/dat SHALL hold their last values.
REQ-017 When wbm_ack_i=1 in BUS, SHALL go to RESP: rsp_dat_o=wbm_dat_i for a read, 0 for a write; rsp_err_o=0; cyc/stb low next cycle.
REQ-018 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-019 On the BUS cycle where the count equals TIMEOUT_CYCLES-1 with no ack, SHALL go to RESP with rsp_err_o=1 and rsp_dat_o=0.
REQ-020 If ack coincides with the timeout cycle, ack SHALL win (rsp_err_o=0).
REQ-021 wbm_ack_i outside BUS SHALL be ignored, with no state or data change.
REQ-022 In RESP, rsp_valid_o SHALL be 1, with rsp_dat_o/rsp_err_o stable until rsp_valid_o & rsp_ready_i; then go to IDLE.
REQ-023 Minimum command-to-command period SHALL be 3 cycles (IDLE, BUS, RESP), with zero-wait ack and rsp_ready_i held 1.
REQ-024 txn_cnt_o SHALL increment by 1 on each BUS-to-RESP transition and wrap modulo 2^CNT_W.
REQ-025 Only one transaction SHALL be outstanding; no pipelining and no burst (CTI/BTE not driven).

Reset
REQ-026 On wb_rst_ni=0, SHALL go asynchronously to IDLE.
REQ-027 Reset values SHALL be: cyc/stb/we=0, sel=0, adr=0, dat=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, txn_cnt_o=0, timeout counter=0.
REQ-028 Reset asserted mid-BUS SHALL drop cyc/stb immediately, with no response generated and the count not incremented.
REQ-029 After reset release, cmd_ready_o SHALL be 1 in the first clocked cycle.

Structure
REQ-030 SHALL place the state enum (IDLE/BUS/RESP) and default TIMEOUT_CYCLES constant in shared package wbm_pkg.
REQ-031 SHALL place the timeout counter in one sub-module wbm_timeout_cnt (clear, enable, expire output); all else inline.
REQ-032 Implementation SHALL be synthesizable single-clock RTL with no latches.

Verification
REQ-033 SHALL cover a write: adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, ack after 2 wait cycles -> cyc/stb high 3 cycles, we=1, rsp_valid with err=0, dat=0, txn_cnt=1.
REQ-034 SHALL cover a read: adr=0x3000_0008, slave returns 0x1234_5678 with zero wait -> rsp_dat_o=0x1234_5678, err=0, cmd-to-rsp_valid latency 2 cycles.
REQ-035 SHALL cover a timeout: TIMEOUT_CYCLES=4, no ack -> cyc/stb high exactly 4 cycles, rsp_err_o=1, rsp_dat_o=0.
REQ-036 SHALL cover ack on the timeout cycle: TIMEOUT_CYCLES=4, ack in the 4th BUS cycle -> rsp_err_o=0, data captured.
REQ-037 SHALL cover backpressure and counter wrap: rsp_ready_i=0 for 5 cycles -> rsp held stable, cmd_ready_o=0; CNT_W=2 with 5 transactions -> txn_cnt_o=1.
REQ-038 SHALL cover reset mid-BUS: wb_rst_ni low on the 2nd BUS cycle -> cyc/stb=0 within the same cycle, no rsp_valid_o, txn_cnt_o=0.
